// File: rtl/mult_pkg.sv
// Shared encodings for the 8x8 sequential multiplier control path.
// State codes match the seven-segment state_out encoding (MULT_SEQ_CTRL_STATE_OUT_EN).
package mult_pkg;

    localparam int CNT_W = 2;
    localparam int SEL_W = 2;

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_LSB  = 3'b001;
    localparam logic [2:0] S_MID  = 3'b010;
    localparam logic [2:0] S_MSB  = 3'b011;
    localparam logic [2:0] S_DONE = 3'b100;
    localparam logic [2:0] S_ERR  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_LSB  = S_LSB,
        ST_MID  = S_MID,
        ST_MSB  = S_MSB,
        ST_DONE = S_DONE,
        ST_ERR  = S_ERR
    } state_e;

    localparam logic [SEL_W-1:0] INSEL_LL = 2'b00;
    localparam logic [SEL_W-1:0] INSEL_LH = 2'b01;
    localparam logic [SEL_W-1:0] INSEL_HL = 2'b10;
    localparam logic [SEL_W-1:0] INSEL_HH = 2'b11;

    localparam logic [SEL_W-1:0] SHIFT_0 = 2'b00;
    localparam logic [SEL_W-1:0] SHIFT_4 = 2'b01;
    localparam logic [SEL_W-1:0] SHIFT_8 = 2'b10;

    // The counter is released only while the FSM sits in a compute state.
    function automatic logic is_compute(input state_e s);
        return (s == ST_LSB) || (s == ST_MID) || (s == ST_MSB);
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Control bundle between the multiplier sequencer (master) and the
// counter / mux / shifter / accumulator datapath (slave).
interface mult_seq_ctrl_if
    import mult_pkg::*;
#(
    parameter int CNT_W = mult_pkg::CNT_W,
    parameter int SEL_W = mult_pkg::SEL_W
);
    logic             start;
    logic [CNT_W-1:0] count;
    logic [SEL_W-1:0] input_sel;
    logic [SEL_W-1:0] shift_sel;
    logic             clk_ena;
    logic             sclr_n;
    logic             cnt_clr_n;
    logic             done;

    modport master (
        input  start,
        input  count,
        output input_sel,
        output shift_sel,
        output clk_ena,
        output sclr_n,
        output cnt_clr_n,
        output done
    );

    modport slave (
        output start,
        output count,
        input  input_sel,
        input  shift_sel,
        input  clk_ena,
        input  sclr_n,
        input  cnt_clr_n,
        input  done
    );
endinterface

// File: rtl/mult_seq_outdec.sv
// Combinational decode of (state, start, count) into the datapath controls.
// Also reports whether the counter agrees with the current compute state.
module mult_seq_outdec
    import mult_pkg::*;
(
    input  state_e           state,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [SEL_W-1:0] input_sel,
    output logic [SEL_W-1:0] shift_sel,
    output logic             clk_ena,
    output logic             sclr_n,
    output logic             done,
    output logic             cnt_ok
);

    always_comb begin
        input_sel = INSEL_LL;
        shift_sel = SHIFT_0;
        clk_ena   = 1'b0;
        sclr_n    = 1'b1;
        done      = 1'b0;
        cnt_ok    = 1'b1;
        case (state)
            // ERR with start restarts exactly like IDLE with start.
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    clk_ena = 1'b1;
                    sclr_n  = 1'b0;
                end
            end
            ST_LSB: begin
                cnt_ok  = (count == CNT_W'(0));
                clk_ena = cnt_ok;
            end
            ST_MID: begin
                if (count == CNT_W'(1)) begin
                    input_sel = INSEL_LH;
                    shift_sel = SHIFT_4;
                    clk_ena   = 1'b1;
                end else if (count == CNT_W'(2)) begin
                    input_sel = INSEL_HL;
                    shift_sel = SHIFT_4;
                    clk_ena   = 1'b1;
                end else begin
                    cnt_ok = 1'b0;
                end
            end
            // A mismatched count leaves the selects at their idle codes.
            ST_MSB: begin
                cnt_ok = (count == CNT_W'(3));
                if (cnt_ok) begin
                    input_sel = INSEL_HH;
                    shift_sel = SHIFT_8;
                    clk_ena   = 1'b1;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer FSM for the 8x8 nibble-serial multiplier (LL, LH, HL, HH).
// Define MULT_SEQ_CTRL_STATE_OUT_EN to expose state_out for the display.
module mult_seq_ctrl
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              aclr_n,
`ifdef MULT_SEQ_CTRL_STATE_OUT_EN
    output logic [2:0]        state_out,
`endif
    mult_seq_ctrl_if.master   bus
);

    state_e state_q;
    state_e state_nxt;
    logic   cnt_clr_n_q;
    logic   cnt_ok;

    mult_seq_outdec u_outdec (
        .state     (state_q),
        .start     (bus.start),
        .count     (bus.count),
        .input_sel (bus.input_sel),
        .shift_sel (bus.shift_sel),
        .clk_ena   (bus.clk_ena),
        .sclr_n    (bus.sclr_n),
        .done      (bus.done),
        .cnt_ok    (cnt_ok)
    );

    // A new start or a counter out of lockstep aborts the product.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_nxt = ST_LSB;
            end
            ST_LSB: begin
                state_nxt = (bus.start || !cnt_ok) ? ST_ERR : ST_MID;
            end
            ST_MID: begin
                if (bus.start || !cnt_ok)
                    state_nxt = ST_ERR;
                else if (bus.count == CNT_W'(2))
                    state_nxt = ST_MSB;
                else
                    state_nxt = ST_MID;
            end
            ST_MSB: begin
                state_nxt = (bus.start || !cnt_ok) ? ST_ERR : ST_DONE;
            end
            ST_DONE: begin
                state_nxt = bus.start ? ST_ERR : ST_IDLE;
            end
            ST_ERR: begin
                if (bus.start) state_nxt = ST_LSB;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // cnt_clr_n is registered so the counter never sees a decode glitch.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q     <= ST_IDLE;
            cnt_clr_n_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_clr_n_q <= is_compute(state_nxt);
        end
    end

    assign bus.cnt_clr_n = cnt_clr_n_q;

`ifdef MULT_SEQ_CTRL_STATE_OUT_EN
    assign state_out = state_q;
`endif

endmodule
